// File: rtl/jtopl_eg_pkg.sv
// Shared definitions for the envelope-generator scheduler: slot count,
// ADSR phase encoding and the layout of one per-slot storage word.
package jtopl_eg_pkg;

  localparam int EG_SLOTS = 18;

  typedef enum logic [1:0] {
    EG_ATTACK  = 2'd0,
    EG_DECAY   = 2'd1,
    EG_SUSTAIN = 2'd2,
    EG_RELEASE = 2'd3
  } eg_phase_t;

  // One storage word per slot: current phase plus the keyon bit seen on
  // the previous visit, used to detect key-on rising edges.
  typedef struct packed {
    eg_phase_t phase;
    logic      keyon;
  } eg_slot_t;

  localparam eg_slot_t EG_SLOT_RESET = '{phase: EG_RELEASE, keyon: 1'b0};

endpackage

// File: rtl/jtopl_eg_slotmem.sv
// Per-slot phase / previous-keyon register array. Read is combinational at
// addr so the top can compute the next phase and write it back to the same
// entry on the same enabled edge.
module jtopl_eg_slotmem
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = EG_SLOTS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     cen,
  input  logic [4:0] addr,
  input  eg_slot_t wr_data,
  output eg_slot_t rd_data
);

  eg_slot_t entry [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_entry
      eg_slot_t entry_reg;

      // Each entry resets to RELEASE / keyon low and only takes a write
      // when it is the addressed slot on an enabled cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= EG_SLOT_RESET;
        end else if (cen && (addr == 5'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entry[gi] = entry_reg;
    end
  endgenerate

  // Read mux; out-of-range addresses never occur but read as reset value.
  always_comb begin
    rd_data = EG_SLOT_RESET;
    for (int i = 0; i < SLOTS; i++) begin
      if (addr == 5'(i)) rd_data = entry[i];
    end
  end

endmodule

// File: rtl/jtopl_eg_sched.sv
// Envelope-generator scheduler: walks all operator slots, keeps each slot's
// ADSR phase, runs the global envelope counter and registers the base rate
// and attack flag for the downstream step block (one enabled cycle latency).
module jtopl_eg_sched
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = EG_SLOTS,
  parameter int CNTW  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            keyon,
  input  logic [3:0]      ar,
  input  logic [3:0]      dr,
  input  logic [3:0]      sl,
  input  logic [3:0]      rr,
  input  logic            eg_type,
  input  logic [8:0]      eg_in,
  output logic [4:0]      slot,
  output logic [4:0]      slot_out,
  output logic [CNTW-1:0] eg_cnt,
  output logic [4:0]      base_rate,
  output logic            attack,
  output logic [1:0]      state
);

  logic [4:0]      slot_reg;
  logic [CNTW-1:0] eg_cnt_reg;
  logic [4:0]      slot_out_reg;
  logic [4:0]      base_rate_reg;
  logic [4:0]      base_rate_next;
  logic            attack_reg;
  eg_phase_t       state_reg;
  eg_phase_t       phase_next;
  eg_slot_t        cur_slot;
  eg_slot_t        wr_slot;
  logic            last_slot;

  assign last_slot = (slot_reg == 5'(SLOTS - 1));

  jtopl_eg_slotmem #(.SLOTS(SLOTS)) u_slotmem (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .addr    (slot_reg),
    .wr_data (wr_slot),
    .rd_data (cur_slot)
  );

  // Phase transition for the slot being visited, highest priority first.
  // The decay threshold compares the top five attenuation bits against sl,
  // with sl=15 stretched to 31 so it means "almost silent".
  always_comb begin
    phase_next = cur_slot.phase;
    if (keyon && !cur_slot.keyon) begin
      phase_next = EG_ATTACK;
    end else if (!keyon) begin
      phase_next = EG_RELEASE;
    end else if (cur_slot.phase == EG_ATTACK && eg_in == 9'd0) begin
      phase_next = EG_DECAY;
    end else if (cur_slot.phase == EG_DECAY && eg_in[8:4] >= {sl == 4'hf, sl}) begin
      phase_next = eg_type ? EG_SUSTAIN : EG_RELEASE;
    end
  end

  // Rate selected by the new phase; sustain uses rate 0 to freeze the level.
  always_comb begin
    base_rate_next = 5'd0;
    case (phase_next)
      EG_ATTACK:  base_rate_next = {ar, 1'b0};
      EG_DECAY:   base_rate_next = {dr, 1'b0};
      EG_SUSTAIN: base_rate_next = 5'd0;
      EG_RELEASE: base_rate_next = {rr, 1'b0};
      default:    base_rate_next = 5'd0;
    endcase
  end

  assign wr_slot = '{phase: phase_next, keyon: keyon};

  // Slot walker, envelope counter and registered per-slot outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg      <= 5'd0;
      eg_cnt_reg    <= '0;
      slot_out_reg  <= 5'd0;
      base_rate_reg <= 5'd0;
      attack_reg    <= 1'b0;
      state_reg     <= EG_RELEASE;
    end else if (cen) begin
      slot_reg      <= last_slot ? 5'd0 : slot_reg + 5'd1;
      if (last_slot) eg_cnt_reg <= eg_cnt_reg + CNTW'(1);
      slot_out_reg  <= slot_reg;
      base_rate_reg <= base_rate_next;
      attack_reg    <= (phase_next == EG_ATTACK);
      state_reg     <= phase_next;
    end
  end

  assign slot      = slot_reg;
  assign eg_cnt    = eg_cnt_reg;
  assign slot_out  = slot_out_reg;
  assign base_rate = base_rate_reg;
  assign attack    = attack_reg;
  assign state     = state_reg;

endmodule

// File: doc/jtopl_eg_sched.md
Name: jtopl_eg_sched

Overview:
- Envelope-generator scheduler for the OPL core.
- Time-multiplexed over all operator slots, it holds a per-slot ADSR phase and the global 15-bit envelope counter.
- Each slot it selects the 5-bit base rate and the attack flag that the downstream envelope step block converts into step/rate.
- It sits between the register/keyon logic and the envelope step/attenuation pipeline.

Parameters:
- SLOTS, 18, number of operator slots visited per sample cycle.
- CNTW, 15, width of the global envelope counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state advances only when cen=1
- keyon  in  1  key-on bit for the slot currently addressed by slot
- ar  in  4  attack rate of current slot
- dr  in  4  decay rate of current slot
- sl  in  4  sustain level of current slot
- rr  in  4  release rate of current slot
- eg_type  in  1  1 = hold at sustain until key-off; 0 = proceed to release after decay
- eg_in  in  9  current attenuation of current slot (0 = loudest, 511 = silent)
- slot  out  5  slot index being sampled this cycle, 0..SLOTS-1
- slot_out  out  5  slot index that the registered outputs refer to
- eg_cnt  out  CNTW  global envelope counter
- base_rate  out  5  rate fed to the step block
- attack  out  1  1 when slot_out is in ATTACK
- state  out  2  phase of slot_out

Behaviour:
- Reset (synchronous, active-high):
  - slot=0, slot_out=0, eg_cnt=0.
  - base_rate=0, attack=0, state=RELEASE.
  - All per-slot phases set to RELEASE; all per-slot previous-keyon bits set to 0.
- cen=0: every register holds, including the slot counter and eg_cnt.
- Slot counter: on each cen it increments; after SLOTS-1 it wraps to 0.
- eg_cnt: increments by 1 on the cen where slot==SLOTS-1; wraps from 2^CNTW-1 to 0.
- Phase encoding: ATTACK=0, DECAY=1, SUSTAIN=2, RELEASE=3.
- Latency: inputs sampled while slot==s produce slot_out=s, state, base_rate and attack on the next cen. Latency is exactly one enabled cycle.
- Next phase for slot s, evaluated by priority:
  1. keyon=1 and previous keyon=0 (rising edge) -> ATTACK.
  2. keyon=0 -> RELEASE.
  3. ATTACK and eg_in==0 -> DECAY.
  4. DECAY and eg_in[8:4] >= {sl==4'hf, sl} -> SUSTAIN if eg_type=1, else RELEASE.
  5. Otherwise hold the current phase.
- Writeback: the new phase and the keyon bit are written into slot s's storage on the same cen.
- Key-on while already in ATTACK with keyon held high: no re-trigger, because an edge is required.
- Key-on rising edge with eg_in already 0: phase still goes to ATTACK; the next visit moves it to DECAY.
- Key-off and a level threshold on the same visit: key-off wins.
- Key-on edge and key-off cannot coincide.
- base_rate follows the new phase (the phase output on the same cycle):
  - ATTACK -> {ar,1'b0}.
  - DECAY -> {dr,1'b0}.
  - SUSTAIN -> 0, which holds the level still.
  - RELEASE -> {rr,1'b0}.
- attack = (new phase == ATTACK).
- Reset asserted mid-sample: everything returns to reset values on that edge; the sequence restarts at slot 0.
- Storage is a SLOTS x 3-bit array (2-bit phase plus previous keyon), read and written at the same index in the same cycle. It is implemented as a register array, not a RAM.

Decomposition:
- Shared package jtopl_eg_pkg:
  - phase constants EG_ATTACK, EG_DECAY, EG_SUSTAIN, EG_RELEASE;
  - EG_SLOTS=18.
- One sub-module: jtopl_eg_slotmem, the per-slot phase/keyon register array with synchronous reset and cen-gated write.
- The transition logic and the counters stay in the top module.

Test Plan:
- Reset then run 36 enabled cycles, all keyon=0 -> state=RELEASE for every slot_out, base_rate={rr,0}; eg_cnt=2 after 36 enabled cycles.
- Slot 3, keyon 0->1, ar=4'hA, eg_in=300 -> next cycle slot_out=3, state=ATTACK, attack=1, base_rate=5'd20. Other slots are unchanged.
- Slot 3 in ATTACK, eg_in=0 on the next visit -> DECAY, base_rate={dr,0}, attack=0.
- Slot 3 in DECAY, sl=4'h2:
  - eg_in=31 -> holds DECAY;
  - eg_in=32 with eg_type=1 -> SUSTAIN, base_rate=0;
  - repeat with eg_type=0 -> RELEASE.
- sl=4'hf in DECAY: eg_in=495 holds DECAY; eg_in=496 moves on. Key-off on the same visit as the threshold -> RELEASE.
- cen low for 10 cycles mid-sample, then reset asserted at slot 9:
  - while cen is low, all outputs and eg_cnt are frozen;
  - after reset, slot=0, eg_cnt=0 and all phases are RELEASE.
